// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, IF/ID
// payload layout and default reset/NOP constants.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD_DEF     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // Instruction word plus its address as handed across the IF/ID boundary
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } ifid_t;

  // Fetch addresses are word aligned; low two bits of any target are dropped
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux: branch target > jump target > PC+4 (32-bit wrap).
// Ports:
//   pc            current fetch address
//   branch_taken  branch resolved taken, target in branch_target
//   jump          jump resolved, target in jump_target
//   redirect_c    either redirect source active
//   target_c      aligned redirect target (branch wins over jump)
//   next_pc_c     target_c on redirect, otherwise pc + 4
module next_pc_select
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            redirect_c,
  output logic [XLEN-1:0] target_c,
  output logic [XLEN-1:0] next_pc_c
);

  always_comb begin
    redirect_c = branch_taken | jump;
    target_c   = align_word(branch_taken ? branch_target : jump_target);
    next_pc_c  = redirect_c ? target_c : pc + XLEN'(4);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, runs the request/ready handshake
// with a variable-latency instruction memory and fills the IF/ID register.
// Ports:
//   Clk, Reset (async, active-low)
//   Stall, BranchTaken/BranchTarget, Jump/JumpTarget   hazard/redirect inputs
//   MemReady, MemRdata                                memory response
//   MemReq, MemAddr                                   memory request
//   PC, Instruction, InstrPC, InstrValid              fetch state / IF/ID
//   FetchCount                                        delivered instructions
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] NOP_WORD     = NOP_WORD_DEF,
  parameter int unsigned     COUNT_WIDTH  = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [XLEN-1:0]        BranchTarget,
  input  logic                   Jump,
  input  logic [XLEN-1:0]        JumpTarget,
  input  logic                   MemReady,
  input  logic [XLEN-1:0]        MemRdata,
  output logic                   MemReq,
  output logic [XLEN-1:0]        MemAddr,
  output logic [XLEN-1:0]        PC,
  output logic [XLEN-1:0]        Instruction,
  output logic [XLEN-1:0]        InstrPC,
  output logic                   InstrValid,
  output logic [COUNT_WIDTH-1:0] FetchCount
);

  fetch_state_e           state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  ifid_t                  ifid_q, ifid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [XLEN-1:0]        hold_buf_q, hold_buf_d;
  logic [XLEN-1:0]        redir_pc_q, redir_pc_d;
  logic                   mem_req_q, mem_req_d;

  logic                   redirect_c;
  logic [XLEN-1:0]        target_c;
  logic [XLEN-1:0]        next_pc_c;

  next_pc_select u_next_pc (
    .pc            (pc_q),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .redirect_c    (redirect_c),
    .target_c      (target_c),
    .next_pc_c     (next_pc_c)
  );

  // State register and datapath flops
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      ifid_q     <= '{instr: NOP_WORD, pc: '0, valid: 1'b0};
      count_q    <= '0;
      hold_buf_q <= '0;
      redir_pc_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      count_q    <= count_d;
      hold_buf_q <= hold_buf_d;
      redir_pc_q <= redir_pc_d;
      mem_req_q  <= mem_req_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    count_d    = count_q;
    hold_buf_d = hold_buf_q;
    redir_pc_d = redir_pc_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        if (MemReady) begin
          if (redirect_c) begin
            ifid_d.instr = NOP_WORD;
            ifid_d.valid = 1'b0;
            pc_d         = next_pc_c;
          end else if (!Stall) begin
            ifid_d  = '{instr: MemRdata, pc: pc_q, valid: 1'b1};
            pc_d    = next_pc_c;
            count_d = count_q + COUNT_WIDTH'(1);
          end else begin
            hold_buf_d = MemRdata;
            state_d    = ST_HOLD;
          end
        end else if (redirect_c) begin
          // Access still outstanding: remember where to go once it completes
          ifid_d.instr = NOP_WORD;
          ifid_d.valid = 1'b0;
          redir_pc_d   = target_c;
          state_d      = ST_DRAIN;
        end else if (!Stall) begin
          ifid_d.instr = NOP_WORD;
          ifid_d.valid = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect_c) begin
          ifid_d.instr = NOP_WORD;
          ifid_d.valid = 1'b0;
          pc_d         = next_pc_c;
          state_d      = ST_REQ;
        end else if (!Stall) begin
          ifid_d  = '{instr: hold_buf_q, pc: pc_q, valid: 1'b1};
          pc_d    = next_pc_c;
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (redirect_c) begin
          ifid_d.instr = NOP_WORD;
          ifid_d.valid = 1'b0;
          redir_pc_d   = target_c;
        end
        // Returned word belongs to the abandoned path and is dropped
        if (MemReady) begin
          pc_d    = redirect_c ? target_c : redir_pc_q;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    mem_req_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
  end

  assign MemReq      = mem_req_q;
  assign MemAddr     = pc_q;
  assign PC          = pc_q;
  assign Instruction = ifid_q.instr;
  assign InstrPC     = ifid_q.pc;
  assign InstrValid  = ifid_q.valid;
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RV  = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall, BranchTaken, Jump, MemReady;
  logic [31:0] BranchTarget, JumpTarget, MemRdata;
  logic        MemReq, InstrValid;
  logic [31:0] MemAddr, PC, Instruction, InstrPC, FetchCount;

  fetch_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .MemReady     (MemReady),
    .MemRdata     (MemRdata),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .PC           (PC),
    .Instruction  (Instruction),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .FetchCount   (FetchCount)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: "started" once the post-reset idle cycle is over,
  // "held" while a stalled word waits, "drain" while an abandoned access
  // is still outstanding.
  bit          m_started, m_held, m_drain;
  logic [31:0] m_pc, m_redir, m_hold_word;
  logic [31:0] m_instr, m_ipc, m_count;
  logic        m_ivalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_held = 0; m_drain = 0;
    m_pc = RV; m_redir = '0; m_hold_word = '0;
    m_instr = NOP; m_ipc = '0; m_ivalid = 1'b0; m_count = '0;
  endtask

  task automatic m_flush();
    m_instr = NOP; m_ivalid = 1'b0;
  endtask

  task automatic m_deliver(input logic [31:0] w);
    m_instr = w; m_ipc = m_pc; m_ivalid = 1'b1;
    m_pc = m_pc + 32'd4;
    m_count = m_count + 32'd1;
  endtask

  // Advance the model by one clock using the inputs presented for that edge
  task automatic model_edge();
    logic        redir;
    logic [31:0] tgt;
    redir = BranchTaken | Jump;
    tgt = BranchTaken ? BranchTarget : JumpTarget;
    tgt[1:0] = 2'b00;
    if (!m_started) begin
      m_started = 1;
    end else if (m_held) begin
      if (redir) begin m_flush(); m_pc = tgt; m_held = 0; end
      else if (!Stall) begin m_deliver(m_hold_word); m_held = 0; end
    end else if (m_drain) begin
      if (redir) begin m_flush(); m_redir = tgt; end
      if (MemReady) begin m_pc = m_redir; m_drain = 0; end
    end else if (MemReady) begin
      if (redir) begin m_flush(); m_pc = tgt; end
      else if (!Stall) m_deliver(MemRdata);
      else begin m_hold_word = MemRdata; m_held = 1; end
    end else if (redir) begin
      m_flush(); m_redir = tgt; m_drain = 1;
    end else if (!Stall) begin
      m_flush();
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".MemReq"},     32'(MemReq),     32'(m_started && !m_held));
    chk({tag, ".MemAddr"},    MemAddr,         m_pc);
    chk({tag, ".PC"},         PC,              m_pc);
    chk({tag, ".InstrValid"}, 32'(InstrValid), 32'(m_ivalid));
    chk({tag, ".InstrPC"},    InstrPC,         m_ipc);
    chk({tag, ".FetchCount"}, FetchCount,      m_count);
    if (m_ivalid) chk({tag, ".Instruction"}, Instruction, m_instr);
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_model(tag);
  endtask

  task automatic quiet_inputs();
    Stall = 0; BranchTaken = 0; Jump = 0; MemReady = 0;
    BranchTarget = '0; JumpTarget = '0; MemRdata = '0;
  endtask

  // Redirect via Jump with MemReady high: lands PC on the target from any busy state
  task automatic goto_pc(input logic [31:0] addr);
    quiet_inputs();
    Jump = 1; JumpTarget = addr; MemReady = 1; MemRdata = 32'hBAD0_BAD0;
    cycle("goto");
    quiet_inputs();
  endtask

  initial begin
    logic [31:0] cnt_before;
    quiet_inputs();
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    check_model("reset");
    chk("reset.Instruction", Instruction, NOP);

    // Back-to-back ready: one instruction per cycle
    Reset = 1'b1;
    cycle("idle");
    for (int i = 0; i < 3; i++) begin
      MemReady = 1;
      MemRdata = 32'hA + 32'(i);
      cycle("b2b");
    end
    chk("b2b.count", FetchCount, 32'd3);
    chk("b2b.ipc", InstrPC, 32'h8);
    chk("b2b.instr", Instruction, 32'hC);
    quiet_inputs();

    // Three-cycle memory latency per access
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        MemReady = 0;
        cycle("lat.wait");
      end
      MemReady = 1; MemRdata = 32'h100 + 32'(k);
      cycle("lat.ready");
      chk("lat.pc", PC, 32'hC + 32'd4 * 32'(k + 1));
      chk("lat.valid", 32'(InstrValid), 32'd1);
    end
    quiet_inputs();

    // Stall when the word arrives: held, then delivered
    goto_pc(32'h10);
    Stall = 1; MemReady = 1; MemRdata = 32'h1234;
    cycle("hold.enter");
    chk("hold.memreq", 32'(MemReq), 32'd0);
    chk("hold.pc", PC, 32'h10);
    MemReady = 0;
    cycle("hold.stay");
    Stall = 0;
    cycle("hold.release");
    chk("hold.instr", Instruction, 32'h1234);
    chk("hold.ipc", InstrPC, 32'h10);
    chk("hold.pc_next", PC, 32'h14);

    // Branch while waiting: outstanding access drains, word dropped
    goto_pc(32'h20);
    cnt_before = m_count;
    BranchTaken = 1; BranchTarget = 32'h103;
    cycle("drain.enter");
    BranchTaken = 0;
    chk("drain.addr0", MemAddr, 32'h20);
    chk("drain.req0", 32'(MemReq), 32'd1);
    cycle("drain.wait");
    chk("drain.addr1", MemAddr, 32'h20);
    MemReady = 1; MemRdata = 32'hDEAD_BEEF;
    cycle("drain.done");
    chk("drain.newaddr", MemAddr, 32'h100);
    chk("drain.count", FetchCount, cnt_before);

    // Branch and jump together with MemReady: branch wins, flush
    MemReady = 1; MemRdata = 32'h7777;
    cycle("prio.deliver");
    BranchTaken = 1; BranchTarget = 32'h200;
    Jump = 1; JumpTarget = 32'h300; MemRdata = 32'h8888;
    cycle("prio.redir");
    chk("prio.pc", PC, 32'h200);
    chk("prio.valid", 32'(InstrValid), 32'd0);
    chk("prio.instr", Instruction, NOP);
    quiet_inputs();

    // PC wrap at the top of the address space
    goto_pc(32'hFFFF_FFFC);
    MemReady = 1; MemRdata = 32'h55;
    cycle("wrap");
    chk("wrap.ipc", InstrPC, 32'hFFFF_FFFC);
    chk("wrap.addr", MemAddr, 32'h0);
    quiet_inputs();

    // Asynchronous reset in the middle of a drain
    Jump = 1; JumpTarget = 32'h40;
    cycle("rst.drain");
    quiet_inputs();
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_model("rst.async");
    chk("rst.pc", PC, RV);
    chk("rst.instr", Instruction, NOP);
    @(posedge Clk);
    @(negedge Clk);
    check_model("rst.held");
    Reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      Stall        = ($urandom % 4) == 0;
      BranchTaken  = ($urandom % 14) == 0;
      Jump         = ($urandom % 14) == 0;
      BranchTarget = $urandom;
      JumpTarget   = $urandom;
      MemReady     = MemReq && (($urandom % 3) != 0);
      MemRdata     = $urandom;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
